// File: rtl/wb_burst_mem_slave_if.sv
// Pipelined Wishbone B4 request/response signal bundle for the burst memory slave.
// Clock and reset stay outside the bundle as plain ports of the slave.
interface wb_burst_mem_slave_if;
    logic [27:0] wbs_adr;
    logic [31:0] wbs_dat_w;
    logic [31:0] wbs_dat_r;
    logic [3:0]  wbs_sel;
    logic        wbs_we;
    logic        wbs_cyc;
    logic        wbs_stb;
    logic        wbs_stall;
    logic        wbs_ack;
    logic        wbs_err;

    modport master (
        output wbs_adr, wbs_dat_w, wbs_sel, wbs_we, wbs_cyc, wbs_stb,
        input  wbs_dat_r, wbs_stall, wbs_ack, wbs_err
    );

    modport slave (
        input  wbs_adr, wbs_dat_w, wbs_sel, wbs_we, wbs_cyc, wbs_stb,
        output wbs_dat_r, wbs_stall, wbs_ack, wbs_err
    );
endinterface

// File: rtl/wb_burst_mem_slave.sv
// Pipelined Wishbone B4 slave over a byte-enabled word RAM with fixed response
// latency, in-order ack/err and a bounded count of outstanding requests.
module wb_burst_mem_slave #(
    parameter int MEM_WORDS       = 256,
    parameter int BASE_WORD       = 0,
    parameter int RD_LATENCY      = 2,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                  sys_clk,
    input  logic                  rst,
    wb_burst_mem_slave_if.slave   wb
);

    localparam int          AW      = $clog2(MEM_WORDS);
    localparam int          CW      = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [27:0] BASE    = 28'(BASE_WORD);
    localparam logic [27:0] DEPTH   = 28'(MEM_WORDS);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUTSTANDING);

    logic [31:0]           mem_q [MEM_WORDS];

    logic [RD_LATENCY-1:0] vld_q, vld_d;
    logic [RD_LATENCY-1:0] err_q, err_d;
    logic [31:0]           dat_q [RD_LATENCY];
    logic [31:0]           dat_d [RD_LATENCY];
    logic [CW-1:0]         cnt_q, cnt_d;

    logic        borrow;
    logic [27:0] offset;
    logic        in_range;
    logic [AW-1:0] widx;
    logic        stall;
    logic        accept;
    logic        resp_v;
    logic        resp_fire;
    logic [31:0] rd_word;

    // Borrow-out of the subtraction doubles as the adr < BASE_WORD test.
    always_comb begin
        {borrow, offset} = {1'b0, wb.wbs_adr} - {1'b0, BASE};
        in_range  = ~borrow && (offset < DEPTH);
        widx      = offset[AW-1:0];
        resp_v    = vld_q[RD_LATENCY-1];
        stall     = (cnt_q == CNT_MAX) & ~resp_v;
        accept    = wb.wbs_cyc & wb.wbs_stb & ~stall;
        resp_fire = resp_v & wb.wbs_cyc;
        rd_word   = (accept & in_range & ~wb.wbs_we) ? mem_q[widx] : '0;
    end

    always_comb begin
        vld_d = '0;
        err_d = '0;
        for (int i = 0; i < RD_LATENCY; i++) dat_d[i] = '0;
        vld_d[0] = accept;
        err_d[0] = accept & ~in_range;
        dat_d[0] = rd_word;
        for (int i = 1; i < RD_LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
            err_d[i] = err_q[i-1];
            dat_d[i] = dat_q[i-1];
        end
        // Dropping cyc abandons everything in flight.
        if (!wb.wbs_cyc) vld_d = '0;
    end

    always_comb begin
        cnt_d = cnt_q;
        if (!wb.wbs_cyc)
            cnt_d = '0;
        else if (accept & ~resp_fire)
            cnt_d = cnt_q + CW'(1);
        else if (~accept & resp_fire)
            cnt_d = cnt_q - CW'(1);
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            err_q <= '0;
            cnt_q <= '0;
            for (int i = 0; i < RD_LATENCY; i++) dat_q[i] <= '0;
        end else begin
            vld_q <= vld_d;
            err_q <= err_d;
            cnt_q <= cnt_d;
            dat_q <= dat_d;
        end
    end

    // RAM contents are deliberately not reset.
    always_ff @(posedge sys_clk) begin
        if (accept & in_range & wb.wbs_we) begin
            for (int b = 0; b < 4; b++) begin
                if (wb.wbs_sel[b]) mem_q[widx][8*b +: 8] <= wb.wbs_dat_w[8*b +: 8];
            end
        end
    end

    assign wb.wbs_stall = stall;
    assign wb.wbs_ack   = resp_fire & ~err_q[RD_LATENCY-1];
    assign wb.wbs_err   = resp_fire &  err_q[RD_LATENCY-1];
    assign wb.wbs_dat_r = (resp_fire & ~err_q[RD_LATENCY-1]) ? dat_q[RD_LATENCY-1] : '0;

endmodule

// File: tb/tb_wb_burst_mem_slave.sv
// Scoreboard bench for wb_burst_mem_slave: one default instance and one with
// a high base address and a single outstanding request.
module tb_wb_burst_mem_slave;

    localparam int LAT = 2;

    typedef struct {
        logic        is_err;
        logic        chk_dat;
        logic [31:0] dat;
        int          t;
    } exp_t;

    logic        sys_clk = 1'b0;
    logic        rst;
    logic [27:0] adr;
    logic [31:0] dat_w;
    logic [3:0]  sel;
    logic        we, cyc, stb;
    logic        which;
    logic        m_ack, m_err, m_stall;
    logic [31:0] m_dat;

    int   n_chk = 0;
    int   n_err = 0;
    int   cyc_n = 0;
    exp_t sb[$];

    wb_burst_mem_slave_if bus0 ();
    wb_burst_mem_slave_if bus1 ();

    wb_burst_mem_slave dut0 (
        .sys_clk (sys_clk),
        .rst     (rst),
        .wb      (bus0.slave)
    );

    wb_burst_mem_slave #(
        .MEM_WORDS       (256),
        .BASE_WORD       ('h100),
        .RD_LATENCY      (2),
        .MAX_OUTSTANDING (1)
    ) dut1 (
        .sys_clk (sys_clk),
        .rst     (rst),
        .wb      (bus1.slave)
    );

    assign bus0.wbs_adr   = adr;
    assign bus0.wbs_dat_w = dat_w;
    assign bus0.wbs_sel   = sel;
    assign bus0.wbs_we    = we;
    assign bus0.wbs_stb   = stb;
    assign bus0.wbs_cyc   = cyc & ~which;
    assign bus1.wbs_adr   = adr;
    assign bus1.wbs_dat_w = dat_w;
    assign bus1.wbs_sel   = sel;
    assign bus1.wbs_we    = we;
    assign bus1.wbs_stb   = stb;
    assign bus1.wbs_cyc   = cyc & which;

    assign m_ack   = which ? bus1.wbs_ack   : bus0.wbs_ack;
    assign m_err   = which ? bus1.wbs_err   : bus0.wbs_err;
    assign m_stall = which ? bus1.wbs_stall : bus0.wbs_stall;
    assign m_dat   = which ? bus1.wbs_dat_r : bus0.wbs_dat_r;

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc_n <= cyc_n + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s obs=%h exp=%h t=%0t", tag, obs, exp_v, $time);
        end
    endtask

    always @(negedge sys_clk) begin
        if (m_ack | m_err) begin
            chk("ack_err_excl", {31'd0, m_ack & m_err}, 32'd0);
            if (sb.size() == 0) begin
                chk("unexpected_resp", {30'd0, m_err, m_ack}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("resp_err", {31'd0, m_err}, {31'd0, e.is_err});
                if (e.chk_dat) chk("resp_dat", m_dat, e.dat);
                chk("resp_lat", cyc_n - e.t, LAT);
            end
        end else begin
            chk("dat_idle", m_dat, 32'd0);
        end
    end

    // Drives one request and holds it until the slave takes it.
    task automatic req(input logic [27:0] a, input logic w, input logic [31:0] d,
                       input logic [3:0] s, input logic e_err, input logic [31:0] e_dat,
                       output int acc_t, output int waits);
        exp_t e;
        adr = a; we = w; dat_w = d; sel = s; cyc = 1'b1; stb = 1'b1;
        waits = 0;
        @(negedge sys_clk);
        while (m_stall && waits < 20) begin
            waits++;
            @(negedge sys_clk);
        end
        if (m_stall) chk("accept_timeout", {31'd0, m_stall}, 32'd0);
        e.is_err  = e_err;
        e.chk_dat = ~w | e_err;
        e.dat     = e_err ? 32'd0 : e_dat;
        e.t       = cyc_n;
        sb.push_back(e);
        acc_t = cyc_n;
        @(posedge sys_clk);
        #1;
    endtask

    task automatic drain();
        stb = 1'b0;
        we  = 1'b0;
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge sys_clk);
        #1;
        chk("drain", sb.size(), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, w, tot, last;
        rst = 1'b1; adr = '0; dat_w = '0; sel = '0; we = 1'b0;
        cyc = 1'b0; stb = 1'b0; which = 1'b0;
        #12;
        chk("rst_ack",   {31'd0, m_ack},   32'd0);
        chk("rst_err",   {31'd0, m_err},   32'd0);
        chk("rst_stall", {31'd0, m_stall}, 32'd0);
        chk("rst_dat",   m_dat,            32'd0);
        @(negedge sys_clk); rst = 1'b0;
        @(posedge sys_clk); #1;

        // Back-to-back writes then reads on the default instance.
        tot = 0;
        for (int i = 0; i < 8; i++) begin
            req(28'(i), 1'b1, 32'hA0 + i, 4'hF, 1'b0, 32'd0, t, w);
            tot += w;
        end
        for (int i = 0; i < 8; i++) begin
            req(28'(i), 1'b0, 32'd0, 4'hF, 1'b0, 32'hA0 + i, t, w);
            tot += w;
        end
        drain();
        chk("t1_stall_cycles", tot, 32'd0);

        // Byte enables.
        req(28'd3, 1'b1, 32'hFFFF_FFFF, 4'hF, 1'b0, 32'd0, t, w);
        req(28'd3, 1'b1, 32'h1122_3344, 4'b0101, 1'b0, 32'd0, t, w);
        req(28'd3, 1'b0, 32'd0, 4'hF, 1'b0, 32'hFF22_FF44, t, w);
        drain();

        // Abort: cyc drops the cycle after the second acceptance.
        req(28'd0, 1'b0, 32'd0, 4'hF, 1'b0, 32'hA0, t, w);
        req(28'd1, 1'b0, 32'd0, 4'hF, 1'b0, 32'hA1, t, w);
        cyc = 1'b0; stb = 1'b0;
        sb.delete();
        @(negedge sys_clk);
        chk("abort_ack", {31'd0, m_ack}, 32'd0);
        chk("abort_err", {31'd0, m_err}, 32'd0);
        @(posedge sys_clk); #1;
        chk("abort_cnt", 32'(dut0.cnt_q), 32'd0);
        req(28'd2, 1'b0, 32'd0, 4'hF, 1'b0, 32'hA2, t, w);
        drain();

        // Asynchronous reset while a response is on the bus.
        req(28'd0, 1'b0, 32'd0, 4'hF, 1'b0, 32'hA0, t, w);
        req(28'd1, 1'b0, 32'd0, 4'hF, 1'b0, 32'hA1, t, w);
        req(28'd2, 1'b0, 32'd0, 4'hF, 1'b0, 32'hA2, t, w);
        stb = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_ack",   {31'd0, m_ack},   32'd0);
        chk("arst_err",   {31'd0, m_err},   32'd0);
        chk("arst_stall", {31'd0, m_stall}, 32'd0);
        chk("arst_dat",   m_dat,            32'd0);
        sb.delete();
        @(negedge sys_clk); #1;
        rst = 1'b0;
        @(posedge sys_clk); #1;
        req(28'd5, 1'b0, 32'd0, 4'hF, 1'b0, 32'hA5, t, w);
        req(28'd3, 1'b0, 32'd0, 4'hF, 1'b0, 32'hFF22_FF44, t, w);
        drain();

        // Second instance: base 0x100, one outstanding request.
        cyc = 1'b0;
        which = 1'b1;
        @(posedge sys_clk); #1;
        req(28'h0FF, 1'b0, 32'd0, 4'hF, 1'b1, 32'd0, t, w);
        req(28'h200, 1'b0, 32'd0, 4'hF, 1'b1, 32'd0, t, w);
        req(28'h1FF, 1'b1, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'd0, t, w);
        req(28'h1FF, 1'b0, 32'd0, 4'hF, 1'b0, 32'hDEAD_BEEF, t, w);
        drain();

        for (int i = 0; i < 6; i++)
            req(28'h100 + 28'(i), 1'b1, 32'hB0 + i, 4'hF, 1'b0, 32'd0, t, w);
        drain();
        last = 0;
        for (int i = 0; i < 6; i++) begin
            req(28'h100 + 28'(i), 1'b0, 32'd0, 4'hF, 1'b0, 32'hB0 + i, t, w);
            if (i > 0) begin
                chk("bp_waits",   w,        32'd1);
                chk("bp_spacing", t - last, 32'd2);
            end
            last = t;
        end
        drain();

        cyc = 1'b0;
        @(posedge sys_clk); #1;
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
